byte_serdes_arith: RTL and testbench
====================================

BYTE_SERDES_ARITH -- requirements
Module: byte_serdes_arith

Interface
REQ-001 Parameter WIDTH, default 24, operand width in bits; WIDTH >= 8.
REQ-002 Parameter NUM_CH, default 2, number of result channels; NUM_CH >= 1.
REQ-003 Parameter LATENCY, default 0, external arithmetic pipeline depth in cycles.
REQ-004 Derived NBYTES = ceil(WIDTH/8) and RBYTES = ceil((WIDTH+1)/8).
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  begins a transaction when sampled high in IDLE.
REQ-008 abort  in  1  returns the block to IDLE from any state.
REQ-009 in_byte  in  8  operand byte, LSB-first.
REQ-010 in_valid  in  1  in_byte qualifier.
REQ-011 sel  in  clog2(NUM_CH) (min 1)  result channel select.
REQ-012 z_in  in  NUM_CH*(WIDTH+1)  flattened external results; channel k at bits [k*(WIDTH+1) +: WIDTH+1].
REQ-013 a, b  out  WIDTH  operand registers driven to the external arithmetic units.
REQ-014 out_ready  in  1  consumer accepts out_byte.
REQ-015 out_byte  out  8  result byte, LSB-first.
REQ-016 out_valid  out  1  out_byte qualifier.
REQ-017 carry  out  1  bit WIDTH of the last captured result.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle pulse on acceptance of the last result byte.

Function
REQ-020 The FSM SHALL have the states IDLE, LOAD_A, LOAD_B, CALC and UNLOAD.
REQ-021 IDLE -> LOAD_A when start=1; the byte counter clears to 0.
REQ-022 start outside IDLE SHALL be ignored.
REQ-023 In LOAD_A/LOAD_B, each cycle with in_valid=1 SHALL write in_byte into byte[cnt] of a/b and increment cnt.
REQ-024 Bits of the final byte above WIDTH-1 SHALL be discarded.
REQ-025 LOAD_A -> LOAD_B, cnt cleared, on acceptance of byte NBYTES-1.
REQ-026 LOAD_B -> CALC, cnt cleared, on acceptance of byte NBYTES-1.
REQ-027 in_valid SHALL be ignored in IDLE, CALC and UNLOAD.
REQ-028 CALC SHALL last exactly LATENCY+1 cycles.
REQ-029 In the last CALC cycle, the block SHALL capture z_in channel sel into the result register, with sel sampled in that same cycle.
REQ-030 sel >= NUM_CH SHALL capture channel 0.
REQ-031 CALC -> UNLOAD, cnt cleared.
REQ-032 carry SHALL update only on capture.
REQ-033 In UNLOAD, out_valid=1 and out_byte = result byte cnt.
REQ-034 Result bits at or above WIDTH+1 SHALL read 0.
REQ-035 cnt SHALL advance only when out_valid & out_ready.
REQ-036 out_byte SHALL be held stable while out_ready=0.
REQ-037 Acceptance of byte RBYTES-1 SHALL move the FSM to IDLE and pulse done for one cycle (the cycle after acceptance).
REQ-038 out_valid SHALL be 0 outside UNLOAD.
REQ-039 abort=1 SHALL force IDLE and cnt=0 next cycle.
REQ-040 abort SHALL NOT modify a, b, the result register or carry.
REQ-041 abort SHALL suppress done.
REQ-042 abort takes priority over start and all data events in the same cycle.
REQ-043 a and b SHALL hold their values in all states except while loading.

Reset
REQ-044 rst=1 SHALL, on the next edge, set the state to IDLE and clear cnt, a, b, the result register, carry, done, out_valid and busy to 0.
REQ-045 rst SHALL take priority over abort, start and all data inputs.
REQ-046 rst asserted mid-transaction SHALL discard the transaction; no done pulse follows.
REQ-047 No output SHALL change asynchronously to clk.

Verification (WIDTH=24, NUM_CH=2, LATENCY=0 unless stated; z_in ch0 = a+b, ch1 = a-b mod 2^25)
REQ-048 start; A bytes 56,34,12; B bytes FF,FF,FF; sel=0; out_ready=1 -> out bytes 55,34,12,01, carry=1, done pulse, then IDLE.
REQ-049 As REQ-048 with in_valid gaps of 3 cycles and out_ready toggling every cycle -> identical bytes, each out_byte held until accepted.
REQ-050 LATENCY=3 with z_in changing each cycle -> capture occurs on the 4th CALC cycle, and busy stays high throughout.
REQ-051 abort asserted after 2 B bytes -> IDLE next cycle, a=0x123456 retained, no done; a fresh transaction then completes correctly.
REQ-052 rst asserted in UNLOAD after 1 byte accepted -> all outputs 0 next cycle, out_valid=0; a subsequent start behaves normally.
REQ-053 WIDTH=12 sweep: A=0xFFF, B=0x001, sel=0 -> a=0x0FFF with upper input bits discarded; out bytes 00,10; carry=1.

Source files
------------

// File: rtl/byte_serdes_arith.sv
// Byte-serial operand loader / result unloader around external arithmetic units.
// Operands arrive LSB-first into a/b; a selected WIDTH+1 result is streamed back out.
module byte_serdes_arith #(
  parameter  int WIDTH   = 24,
  parameter  int NUM_CH  = 2,
  parameter  int LATENCY = 0,
  localparam int SELW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [7:0]                   in_byte,
  input  logic                         in_valid,
  input  logic [SELW-1:0]              sel,
  input  logic [NUM_CH*(WIDTH+1)-1:0]  z_in,
  output logic [WIDTH-1:0]             a,
  output logic [WIDTH-1:0]             b,
  input  logic                         out_ready,
  output logic [7:0]                   out_byte,
  output logic                         out_valid,
  output logic                         carry,
  output logic                         busy,
  output logic                         done
);

  localparam int NBYTES = (WIDTH + 7) / 8;
  localparam int RBYTES = (WIDTH + 8) / 8;
  localparam int CW     = $clog2(RBYTES + 1);
  localparam int LW     = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, CALC, UNLOAD} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [LW-1:0]       lat_cnt;
  logic [WIDTH:0]      result;
  logic [WIDTH-1:0]    ld_val;
  logic [RBYTES*8-1:0] res_ext;
  logic [WIDTH:0]      z_sel;
  logic                last_in;
  logic                last_out;

  // Byte insertion is done bit-wise so bits of the top byte above WIDTH-1 simply fall away.
  always_comb begin
    ld_val = (state == LOAD_B) ? b : a;
    for (int unsigned j = 0; j < WIDTH; j++)
      if (cnt == CW'(j / 8)) ld_val[j] = in_byte[j % 8];

    res_ext = '0;
    res_ext[WIDTH:0] = result;
    out_byte = '0;
    for (int unsigned i = 0; i < RBYTES; i++)
      if (cnt == CW'(i)) out_byte = res_ext[i*8 +: 8];

    // Unmatched select codes (sel >= NUM_CH) fall through to channel 0.
    z_sel = z_in[WIDTH:0];
    for (int unsigned k = 1; k < NUM_CH; k++)
      if (sel == SELW'(k)) z_sel = z_in[k*(WIDTH+1) +: WIDTH+1];

    last_in  = (cnt == CW'(NBYTES - 1));
    last_out = (cnt == CW'(RBYTES - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_cnt   <= '0;
      a         <= '0;
      b         <= '0;
      result    <= '0;
      carry     <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        cnt       <= '0;
        out_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            state <= LOAD_A;
            cnt   <= '0;
            busy  <= 1'b1;
          end
          LOAD_A: if (in_valid) begin
            a <= ld_val;
            if (last_in) begin
              state <= LOAD_B;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          LOAD_B: if (in_valid) begin
            b <= ld_val;
            if (last_in) begin
              state   <= CALC;
              cnt     <= '0;
              lat_cnt <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          CALC: begin
            if (lat_cnt == LW'(LATENCY)) begin
              result    <= z_sel;
              carry     <= z_sel[WIDTH];
              state     <= UNLOAD;
              cnt       <= '0;
              out_valid <= 1'b1;
            end else begin
              lat_cnt <= lat_cnt + LW'(1);
            end
          end
          UNLOAD: if (out_ready) begin
            if (last_out) begin
              state     <= IDLE;
              cnt       <= '0;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_byte_serdes_arith.sv
// Scoreboard bench: two instances (24-bit/2ch/lat0 and 12-bit/3ch/lat3) driven with
// random and directed transactions; a negedge monitor compares streamed bytes.
module tb_byte_serdes_arith;

  localparam int W0 = 24, C0 = 2, L0 = 0;
  localparam int W1 = 12, C1 = 3, L1 = 3;

  typedef struct packed {
    logic [7:0] by;
    logic       c;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2], start[2], abort[2], in_valid[2], out_ready[2];
  logic [7:0]  in_byte[2];
  logic [1:0]  sel[2];
  logic [23:0] a_o[2], b_o[2];
  logic [7:0]  ob[2];
  logic        ov[2], cy[2], bz[2], dn[2];

  logic [W0-1:0]          a0, b0;
  logic [W1-1:0]          a1, b1;
  logic [2*(W0+1)-1:0]    z0;
  logic [3*(W1+1)-1:0]    z1;
  logic [12:0]            tick = '0;

  always @(posedge clk) tick <= tick + 13'd1;

  // External arithmetic: ch0 sum, ch1 difference, ch2 (instance 1 only) varies every cycle.
  assign z0 = {{1'b0, a0} - {1'b0, b0}, {1'b0, a0} + {1'b0, b0}};
  assign z1 = {{1'b0, a1 ^ b1} + tick, {1'b0, a1} - {1'b0, b1}, {1'b0, a1} + {1'b0, b1}};
  assign a_o[0] = a0;
  assign b_o[0] = b0;
  assign a_o[1] = {12'b0, a1};
  assign b_o[1] = {12'b0, b1};

  byte_serdes_arith #(.WIDTH(W0), .NUM_CH(C0), .LATENCY(L0)) dut0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .abort(abort[0]),
    .in_byte(in_byte[0]), .in_valid(in_valid[0]), .sel(sel[0][0]), .z_in(z0),
    .a(a0), .b(b0), .out_ready(out_ready[0]), .out_byte(ob[0]),
    .out_valid(ov[0]), .carry(cy[0]), .busy(bz[0]), .done(dn[0]));

  byte_serdes_arith #(.WIDTH(W1), .NUM_CH(C1), .LATENCY(L1)) dut1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .abort(abort[1]),
    .in_byte(in_byte[1]), .in_valid(in_valid[1]), .sel(sel[1]), .z_in(z1),
    .a(a1), .b(b1), .out_ready(out_ready[1]), .out_byte(ob[1]),
    .out_valid(ov[1]), .carry(cy[1]), .busy(bz[1]), .done(dn[1]));

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[2][$];
  bit   done_exp[2];
  bit   done_seen[2];
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] @%0t: got %0h expected %0h", nm, i, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: operands truncated to WIDTH, channel chosen, result taken mod 2^(WIDTH+1).
  function automatic logic [31:0] model(input int i, input logic [31:0] A, input logic [31:0] B,
                                        input int s, input logic [12:0] tk);
    int w, nch, ch;
    longint unsigned m, rm, am, bm, r;
    w   = (i == 0) ? W0 : W1;
    nch = (i == 0) ? C0 : C1;
    m   = (64'd1 << w) - 1;
    rm  = (64'd1 << (w + 1)) - 1;
    am  = A & m;
    bm  = B & m;
    ch  = (s >= nch) ? 0 : s;
    case (ch)
      0:       r = am + bm;
      1:       r = am - bm;
      default: r = (am ^ bm) + tk;
    endcase
    return 32'(r & rm);
  endfunction

  function automatic logic [31:0] mask(input int i);
    return (i == 0) ? 32'hFF_FFFF : 32'h0FFF;
  endfunction

  always @(negedge clk) begin
    bit ev;
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        ev = (sb[i].size() != 0);
        chk("out_valid", i, 32'(ov[i]), 32'(ev));
        if (ev) begin
          chk("out_byte", i, 32'(ob[i]), 32'(sb[i][0].by));
          chk("carry", i, 32'(cy[i]), 32'(sb[i][0].c));
        end
        chk("done", i, 32'(dn[i]), 32'(done_exp[i]));
        if (done_exp[i] && dn[i]) done_seen[i] = 1'b1;
        done_exp[i] = 1'b0;
        if (rst[i] || abort[i]) sb[i].delete();
        else if (ev && out_ready[i]) begin
          void'(sb[i].pop_front());
          if (sb[i].size() == 0) done_exp[i] = 1'b1;
        end
      end
    end
  end

  // Starts a transaction, loads both operands, runs CALC and queues the expected bytes.
  task automatic load_calc(input int i, input logic [31:0] A, input logic [31:0] B,
                           input int gap, input bit rnd_gap, input int sel_fix,
                           output logic [31:0] r);
    int nb, lat, s, g, rb, w;
    logic [12:0] tk;
    exp_t e;
    nb  = (i == 0) ? 3 : 2;
    rb  = (i == 0) ? 4 : 2;
    w   = (i == 0) ? W0 : W1;
    lat = (i == 0) ? L0 : L1;
    s   = 0;
    tk  = '0;
    done_seen[i] = 1'b0;
    start[i] = 1'b1;
    cyc();
    start[i] = 1'b0;
    chk("busy_load", i, 32'(bz[i]), 32'd1);
    for (int op = 0; op < 2; op++) begin
      for (int k = 0; k < nb; k++) begin
        g = rnd_gap ? int'($urandom_range(gap, 0)) : gap;
        repeat (g) begin
          in_valid[i] = 1'b0;
          in_byte[i]  = 8'($urandom);
          start[i]    = 1'($urandom_range(1, 0));
          cyc();
        end
        start[i]    = 1'b0;
        in_valid[i] = 1'b1;
        in_byte[i]  = (op == 0) ? A[8*k +: 8] : B[8*k +: 8];
        cyc();
        in_valid[i] = 1'b0;
      end
    end
    for (int c = 0; c <= lat; c++) begin
      s = (sel_fix >= 0) ? sel_fix : int'($urandom_range((i == 0) ? 1 : 3, 0));
      sel[i]      = 2'(s);
      tk          = tick;
      in_valid[i] = 1'($urandom_range(1, 0));
      in_byte[i]  = 8'($urandom);
      chk("busy_calc", i, 32'(bz[i]), 32'd1);
      cyc();
    end
    in_valid[i] = 1'b0;
    r = model(i, A, B, s, tk);
    for (int k = 0; k < rb; k++) begin
      e.by = r[8*k +: 8];
      e.c  = r[w];
      sb[i].push_back(e);
    end
  endtask

  task automatic unload(input int i, input int mode);
    int t;
    t = 0;
    while (!done_seen[i] && t < 200) begin
      out_ready[i] = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(t % 2) : 1'($urandom_range(1, 0));
      in_valid[i]  = 1'($urandom_range(1, 0));
      in_byte[i]   = 8'($urandom);
      cyc();
      t++;
    end
    out_ready[i] = 1'b0;
    in_valid[i]  = 1'b0;
    chk("done_seen", i, 32'(done_seen[i]), 32'd1);
    chk("busy_idle", i, 32'(bz[i]), 32'd0);
  endtask

  task automatic txn(input int i, input logic [31:0] A, input logic [31:0] B, input int gap,
                     input bit rnd_gap, input int mode, input int sel_fix);
    logic [31:0] r;
    load_calc(i, A, B, gap, rnd_gap, sel_fix, r);
    unload(i, mode);
    chk("a_hold", i, 32'(a_o[i]), A & mask(i));
    chk("b_hold", i, 32'(b_o[i]), B & mask(i));
  endtask

  initial begin
    logic [7:0]  seq[5];
    logic [31:0] r;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; abort[i] = 1'b0; in_valid[i] = 1'b0;
      out_ready[i] = 1'b0; in_byte[i] = '0; sel[i] = '0;
      done_exp[i] = 1'b0; done_seen[i] = 1'b0;
    end
    repeat (3) cyc();
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0;
      chk("rst_a", i, 32'(a_o[i]), 32'd0);
      chk("rst_b", i, 32'(b_o[i]), 32'd0);
      chk("rst_carry", i, 32'(cy[i]), 32'd0);
      chk("rst_busy", i, 32'(bz[i]), 32'd0);
      chk("rst_valid", i, 32'(ov[i]), 32'd0);
      chk("rst_done", i, 32'(dn[i]), 32'd0);
    end
    mon_en = 1'b1;

    // Reference vector, then the same with input gaps and a toggling consumer.
    txn(0, 32'h123456, 32'hFFFFFF, 0, 1'b0, 0, 0);
    chk("carry_ref", 0, 32'(cy[0]), 32'd1);
    txn(0, 32'h123456, 32'hFFFFFF, 3, 1'b0, 1, 0);
    chk("carry_gap", 0, 32'(cy[0]), 32'd1);

    // 12-bit: upper nibble of the top operand byte must be dropped.
    txn(1, 32'hFFFF, 32'h0001, 0, 1'b0, 0, 0);
    chk("carry_w12", 1, 32'(cy[1]), 32'd1);

    // Time-varying channel on the 4-cycle CALC instance, and sel beyond the channel count.
    txn(1, 32'h0ABC, 32'h0123, 0, 1'b0, 0, 2);
    txn(1, 32'h0F00, 32'h0234, 1, 1'b1, 2, 3);

    // Abort after two B bytes, with a competing B byte in the abort cycle.
    seq = '{8'h56, 8'h34, 8'h12, 8'hFF, 8'hFF};
    start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid[0] = 1'b1;
      in_byte[0]  = seq[k];
      cyc();
    end
    abort[0] = 1'b1;
    in_byte[0] = 8'hFF;
    cyc();
    abort[0] = 1'b0;
    chk("abort_busy", 0, 32'(bz[0]), 32'd0);
    chk("abort_a", 0, 32'(a_o[0]), 32'h123456);
    cyc();
    in_valid[0] = 1'b0;
    chk("abort_idle", 0, 32'(bz[0]), 32'd0);
    txn(0, 32'h123456, 32'hFFFFFF, 0, 1'b0, 0, 0);

    // abort and start together in IDLE: abort wins.
    start[1] = 1'b1;
    abort[1] = 1'b1;
    cyc();
    start[1] = 1'b0;
    abort[1] = 1'b0;
    chk("abort_vs_start", 1, 32'(bz[1]), 32'd0);

    // Abort mid-unload keeps carry and operands, no done.
    load_calc(1, 32'h0FFF, 32'h0FFF, 0, 1'b0, 0, r);
    out_ready[1] = 1'b1;
    cyc();
    out_ready[1] = 1'b0;
    abort[1] = 1'b1;
    cyc();
    abort[1] = 1'b0;
    chk("abort_ul_busy", 1, 32'(bz[1]), 32'd0);
    chk("abort_ul_carry", 1, 32'(cy[1]), 32'(r[W1]));
    chk("abort_ul_a", 1, 32'(a_o[1]), 32'h0FFF);
    cyc();

    // Reset in UNLOAD after one accepted byte.
    load_calc(0, 32'h800000, 32'h800001, 0, 1'b0, 0, r);
    out_ready[0] = 1'b1;
    cyc();
    out_ready[0] = 1'b0;
    rst[0] = 1'b1;
    cyc();
    rst[0] = 1'b0;
    chk("urst_a", 0, 32'(a_o[0]), 32'd0);
    chk("urst_b", 0, 32'(b_o[0]), 32'd0);
    chk("urst_carry", 0, 32'(cy[0]), 32'd0);
    chk("urst_busy", 0, 32'(bz[0]), 32'd0);
    chk("urst_valid", 0, 32'(ov[0]), 32'd0);
    chk("urst_byte", 0, 32'(ob[0]), 32'd0);
    cyc();
    txn(0, 32'hABCDEF, 32'h000011, 0, 1'b0, 0, 1);

    repeat (25) begin
      for (int i = 0; i < 2; i++)
        txn(i, $urandom, $urandom, 2, 1'b1, int'($urandom_range(2, 0)), -1);
    end

    repeat (3) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
